// File: rtl/reorder_buffer_pkg.sv
// Shared sizes, entry layout and helpers for the in-order reorder buffer.
package reorder_buffer_pkg;

    localparam int unsigned ROB_SIZE      = 16;
    localparam int unsigned ROB_TAG_W     = 4;
    localparam int unsigned ROB_TAG_WIDTH = ROB_TAG_W;
    localparam int unsigned DATA_W        = 32;
    localparam int unsigned REG_TAG_W     = 5;
    localparam int unsigned CNT_W         = ROB_TAG_W + 1;

    // Register index 0 on the commit port means "nothing written this cycle".
    localparam logic [REG_TAG_W-1:0] NO_COMMIT_REG = '0;

    typedef struct packed {
        logic [REG_TAG_W-1:0] dest_reg;
        logic [DATA_W-1:0]    value;
        logic                 ready;
        logic                 mispredict;
        logic [DATA_W-1:0]    target_pc;
    } rob_entry_t;

    function automatic logic [ROB_TAG_W-1:0] tag_next(input logic [ROB_TAG_W-1:0] tag);
        return tag + ROB_TAG_W'(1);
    endfunction

endpackage

// File: rtl/reorder_buffer.sv
// Circular in-order reorder buffer: allocates tags to the decoder, captures CDB
// results, retires in program order and flushes on a retiring mispredict.
module reorder_buffer
    import reorder_buffer_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rdy,
    input  logic                 in_decode_valid,
    input  logic [REG_TAG_W-1:0] in_decode_dest_reg,
    output logic [ROB_TAG_W-1:0] out_decode_tag,
    output logic                 out_rob_full,
    input  logic                 in_cdb_valid,
    input  logic [ROB_TAG_W-1:0] in_cdb_tag,
    input  logic [DATA_W-1:0]    in_cdb_value,
    input  logic                 in_cdb_mispredict,
    input  logic [DATA_W-1:0]    in_cdb_target_pc,
    input  logic [ROB_TAG_W-1:0] in_query_tag1,
    input  logic [ROB_TAG_W-1:0] in_query_tag2,
    output logic                 out_query_ready1,
    output logic                 out_query_ready2,
    output logic [DATA_W-1:0]    out_query_value1,
    output logic [DATA_W-1:0]    out_query_value2,
    output logic [REG_TAG_W-1:0] out_commit_reg,
    output logic [ROB_TAG_W-1:0] out_commit_rob,
    output logic [DATA_W-1:0]    out_commit_value,
    output logic                 out_flush,
    output logic [DATA_W-1:0]    out_flush_pc
);

    rob_entry_t           entries [ROB_SIZE];
    logic [ROB_TAG_W-1:0] head;
    logic [ROB_TAG_W-1:0] tail;
    logic [CNT_W-1:0]     count;

    rob_entry_t head_entry;
    logic       commit_c;
    logic       flush_now_c;
    logic       alloc_c;
    logic       cdb_wr_c;
    logic       q1_hit_c;
    logic       q2_hit_c;

    // Retire/flush/alloc decisions, all from start-of-cycle state.
    always_comb begin
        head_entry  = entries[head];
        commit_c    = rdy && (count != '0) && head_entry.ready;
        flush_now_c = commit_c && head_entry.mispredict;
        alloc_c     = rdy && in_decode_valid && !out_rob_full && !flush_now_c;
        cdb_wr_c    = rdy && in_cdb_valid && !flush_now_c;
    end

    assign out_decode_tag = tail;
    assign out_rob_full   = (count == CNT_W'(ROB_SIZE));

    // Operand lookup with same-cycle bypass from the CDB.
    always_comb begin
        q1_hit_c         = in_cdb_valid && (in_cdb_tag == in_query_tag1);
        q2_hit_c         = in_cdb_valid && (in_cdb_tag == in_query_tag2);
        out_query_ready1 = entries[in_query_tag1].ready || q1_hit_c;
        out_query_ready2 = entries[in_query_tag2].ready || q2_hit_c;
        out_query_value1 = q1_hit_c ? in_cdb_value : entries[in_query_tag1].value;
        out_query_value2 = q2_hit_c ? in_cdb_value : entries[in_query_tag2].value;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head             <= '0;
            tail             <= '0;
            count            <= '0;
            out_commit_reg   <= NO_COMMIT_REG;
            out_commit_rob   <= '0;
            out_commit_value <= '0;
            out_flush        <= 1'b0;
            out_flush_pc     <= '0;
            for (int unsigned i = 0; i < ROB_SIZE; i++) begin
                entries[ROB_TAG_W'(i)] <= '0;
            end
        end else if (rdy) begin
            out_commit_reg   <= commit_c ? head_entry.dest_reg : NO_COMMIT_REG;
            out_commit_rob   <= head;
            out_commit_value <= head_entry.value;
            out_flush        <= flush_now_c;
            out_flush_pc     <= flush_now_c ? head_entry.target_pc : '0;

            if (flush_now_c) begin
                // The mispredicted entry still retires; everything younger is dropped.
                head  <= '0;
                tail  <= '0;
                count <= '0;
                for (int unsigned i = 0; i < ROB_SIZE; i++) begin
                    entries[ROB_TAG_W'(i)].ready      <= 1'b0;
                    entries[ROB_TAG_W'(i)].mispredict <= 1'b0;
                end
            end else begin
                if (alloc_c) begin
                    entries[tail].dest_reg   <= in_decode_dest_reg;
                    entries[tail].ready      <= 1'b0;
                    entries[tail].mispredict <= 1'b0;
                    tail                     <= tag_next(tail);
                end
                // Written after the allocation so a CDB hit on the tail slot wins.
                if (cdb_wr_c) begin
                    entries[in_cdb_tag].value      <= in_cdb_value;
                    entries[in_cdb_tag].ready      <= 1'b1;
                    entries[in_cdb_tag].mispredict <= in_cdb_mispredict;
                    entries[in_cdb_tag].target_pc  <= in_cdb_target_pc;
                end
                if (commit_c) begin
                    head <= tag_next(head);
                end
                case ({alloc_c, commit_c})
                    2'b10:   count <= count + CNT_W'(1);
                    2'b01:   count <= count - CNT_W'(1);
                    default: count <= count;
                endcase
            end
        end else begin
            out_commit_reg <= NO_COMMIT_REG;
            out_flush      <= 1'b0;
        end
    end

endmodule

// File: tb/tb_reorder_buffer.sv
// Directed and randomized bench for reorder_buffer against a queue-style
// model of program-order allocation, out-of-order completion and retirement.
module tb_reorder_buffer;

    logic        clk;
    logic        rst;
    logic        rdy;
    logic        in_decode_valid;
    logic [4:0]  in_decode_dest_reg;
    logic [3:0]  out_decode_tag;
    logic        out_rob_full;
    logic        in_cdb_valid;
    logic [3:0]  in_cdb_tag;
    logic [31:0] in_cdb_value;
    logic        in_cdb_mispredict;
    logic [31:0] in_cdb_target_pc;
    logic [3:0]  in_query_tag1;
    logic [3:0]  in_query_tag2;
    logic        out_query_ready1;
    logic        out_query_ready2;
    logic [31:0] out_query_value1;
    logic [31:0] out_query_value2;
    logic [4:0]  out_commit_reg;
    logic [3:0]  out_commit_rob;
    logic [31:0] out_commit_value;
    logic        out_flush;
    logic [31:0] out_flush_pc;

    reorder_buffer dut (
        .clk                (clk),
        .rst                (rst),
        .rdy                (rdy),
        .in_decode_valid    (in_decode_valid),
        .in_decode_dest_reg (in_decode_dest_reg),
        .out_decode_tag     (out_decode_tag),
        .out_rob_full       (out_rob_full),
        .in_cdb_valid       (in_cdb_valid),
        .in_cdb_tag         (in_cdb_tag),
        .in_cdb_value       (in_cdb_value),
        .in_cdb_mispredict  (in_cdb_mispredict),
        .in_cdb_target_pc   (in_cdb_target_pc),
        .in_query_tag1      (in_query_tag1),
        .in_query_tag2      (in_query_tag2),
        .out_query_ready1   (out_query_ready1),
        .out_query_ready2   (out_query_ready2),
        .out_query_value1   (out_query_value1),
        .out_query_value2   (out_query_value2),
        .out_commit_reg     (out_commit_reg),
        .out_commit_rob     (out_commit_rob),
        .out_commit_value   (out_commit_value),
        .out_flush          (out_flush),
        .out_flush_pc       (out_flush_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: slot contents by tag, plus oldest-slot index and occupancy.
    int          m_head;
    int          m_count;
    logic [4:0]  m_dest [16];
    logic [31:0] m_val  [16];
    logic [31:0] m_tgt  [16];
    bit          m_rdy  [16];
    bit          m_mis  [16];

    logic [3:0]  obs_dtag;
    logic        obs_qr1;
    logic [31:0] obs_qv1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_head  = 0;
        m_count = 0;
        for (int i = 0; i < 16; i++) begin
            m_dest[i] = '0;
            m_val[i]  = '0;
            m_tgt[i]  = '0;
            m_rdy[i]  = 1'b0;
            m_mis[i]  = 1'b0;
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_commit_reg"},   32'(out_commit_reg), 32'd0);
        chk({tag, "_commit_rob"},   32'(out_commit_rob), 32'd0);
        chk({tag, "_commit_value"}, out_commit_value,    32'd0);
        chk({tag, "_flush"},        32'(out_flush),      32'd0);
        chk({tag, "_flush_pc"},     out_flush_pc,        32'd0);
        chk({tag, "_full"},         32'(out_rob_full),   32'd0);
        chk({tag, "_decode_tag"},   32'(out_decode_tag), 32'd0);
    endtask

    task automatic drive_idle();
        rdy                = 1'b1;
        in_decode_valid    = 1'b0;
        in_decode_dest_reg = '0;
        in_cdb_valid       = 1'b0;
        in_cdb_tag         = '0;
        in_cdb_value       = '0;
        in_cdb_mispredict  = 1'b0;
        in_cdb_target_pc   = '0;
        in_query_tag1      = '0;
        in_query_tag2      = '0;
    endtask

    // Called just after a rising edge; leaves time just after the next rising edge.
    task automatic do_reset();
        rst = 1'b1;
        drive_idle();
        #1;
        chk_reset_outputs("rst");
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic qcheck(input string tag, input int q, input bit cv, input int ct,
                          input logic [31:0] cval, input logic obs_r, input logic [31:0] obs_v);
        bit          e_r;
        logic [31:0] e_v;
        e_r = m_rdy[q] || (cv && ct == q);
        e_v = (cv && ct == q) ? cval : m_val[q];
        chk({tag, "_ready"}, 32'(obs_r), 32'(e_r));
        if (e_r) chk({tag, "_value"}, obs_v, e_v);
    endtask

    // One clock cycle: apply inputs, check combinational outputs, advance the model,
    // then check the registered outputs after the edge.
    task automatic step(input bit r, input bit dv, input int dr,
                        input bit cv, input int ct, input logic [31:0] cval,
                        input bit cm, input logic [31:0] cpc,
                        input int q1, input int q2);
        int          tail;
        bit          full;
        bit          commit;
        bit          flush;
        logic [4:0]  e_reg;
        int          e_rob;
        logic [31:0] e_val;
        logic [31:0] e_pc;

        rdy                = r;
        in_decode_valid    = dv;
        in_decode_dest_reg = 5'(dr);
        in_cdb_valid       = cv;
        in_cdb_tag         = 4'(ct);
        in_cdb_value       = cval;
        in_cdb_mispredict  = cm;
        in_cdb_target_pc   = cpc;
        in_query_tag1      = 4'(q1);
        in_query_tag2      = 4'(q2);
        #1;

        tail = (m_head + m_count) % 16;
        full = (m_count == 16);
        obs_dtag = out_decode_tag;
        obs_qr1  = out_query_ready1;
        obs_qv1  = out_query_value1;
        chk("decode_tag", 32'(out_decode_tag), 32'(tail));
        chk("rob_full",   32'(out_rob_full),   32'(full));
        qcheck("query1", q1, cv, ct, cval, out_query_ready1, out_query_value1);
        qcheck("query2", q2, cv, ct, cval, out_query_ready2, out_query_value2);

        commit = r && (m_count != 0) && m_rdy[m_head];
        flush  = commit && m_mis[m_head];
        e_reg  = commit ? m_dest[m_head] : 5'd0;
        e_rob  = m_head;
        e_val  = m_val[m_head];
        e_pc   = m_tgt[m_head];

        if (r) begin
            if (flush) begin
                m_head  = 0;
                m_count = 0;
                for (int i = 0; i < 16; i++) begin
                    m_rdy[i] = 1'b0;
                    m_mis[i] = 1'b0;
                end
            end else begin
                if (dv && !full) begin
                    m_dest[tail] = 5'(dr);
                    m_rdy[tail]  = 1'b0;
                    m_mis[tail]  = 1'b0;
                    m_count++;
                end
                if (cv) begin
                    m_val[ct] = cval;
                    m_rdy[ct] = 1'b1;
                    m_mis[ct] = cm;
                    m_tgt[ct] = cpc;
                end
                if (commit) begin
                    m_head = (m_head + 1) % 16;
                    m_count--;
                end
            end
        end

        @(posedge clk);
        #1;
        chk("commit_reg", 32'(out_commit_reg), 32'(e_reg));
        if (commit) begin
            chk("commit_rob",   32'(out_commit_rob), 32'(e_rob));
            chk("commit_value", out_commit_value,    e_val);
        end
        chk("flush", 32'(out_flush), 32'(flush));
        if (flush) chk("flush_pc", out_flush_pc, e_pc);
    endtask

    task automatic alloc(input int dr);
        step(1'b1, 1'b1, dr, 1'b0, 0, 32'd0, 1'b0, 32'd0, 0, 0);
    endtask

    task automatic cdb(input int ct, input logic [31:0] v, input bit m, input logic [31:0] pc);
        step(1'b1, 1'b0, 0, 1'b1, ct, v, m, pc, ct, 0);
    endtask

    task automatic idle();
        step(1'b1, 1'b0, 0, 1'b0, 0, 32'd0, 1'b0, 32'd0, 0, 1);
    endtask

    initial begin
        rst = 1'b1;
        drive_idle();
        model_reset();
        #3;
        chk_reset_outputs("por");
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Single allocate, complete, retire.
        alloc(5);
        chk("tp1_tag", 32'(obs_dtag), 32'd0);
        cdb(0, 32'h1234, 1'b0, 32'd0);
        idle();
        chk("tp1_reg", 32'(out_commit_reg),   32'd5);
        chk("tp1_rob", 32'(out_commit_rob),   32'd0);
        chk("tp1_val", out_commit_value,      32'h1234);
        idle();
        chk("tp1_none", 32'(out_commit_reg), 32'd0);

        // Out-of-order completion retires in order.
        do_reset();
        alloc(7);
        alloc(8);
        cdb(1, 32'hB, 1'b0, 32'd0);
        cdb(0, 32'hA, 1'b0, 32'd0);
        idle();
        chk("tp2_rob0", 32'(out_commit_rob), 32'd0);
        chk("tp2_val0", out_commit_value,    32'hA);
        idle();
        chk("tp2_rob1", 32'(out_commit_rob), 32'd1);
        chk("tp2_val1", out_commit_value,    32'hB);

        // Fill, ignore overflow request, forward, then retire one and wrap the tail.
        do_reset();
        for (int i = 0; i < 16; i++) alloc(i + 1);
        chk("tp3_full", 32'(out_rob_full), 32'd1);
        alloc(30);
        chk("tp3_still_full", 32'(out_rob_full), 32'd1);
        step(1'b1, 1'b0, 0, 1'b1, 3, 32'h77, 1'b0, 32'd0, 3, 3);
        chk("tp4_fwd_ready", 32'(obs_qr1), 32'd1);
        chk("tp4_fwd_value", obs_qv1,      32'h77);
        cdb(0, 32'h55, 1'b0, 32'd0);
        alloc(20);
        chk("tp3_commit_head", 32'(out_commit_reg), 32'd1);
        alloc(21);
        chk("tp3_wrap_tag", 32'(obs_dtag),      32'd0);
        chk("tp3_refull",   32'(out_rob_full), 32'd1);

        // Retiring mispredict: link value commits, one-cycle flush, buffer empties.
        do_reset();
        alloc(1);
        alloc(2);
        alloc(3);
        cdb(0, 32'h44, 1'b1, 32'h100);
        idle();
        chk("tp5_flush",    32'(out_flush),      32'd1);
        chk("tp5_flush_pc", out_flush_pc,        32'h100);
        chk("tp5_link",     32'(out_commit_reg), 32'd1);
        idle();
        chk("tp5_flush_once", 32'(out_flush),    32'd0);
        chk("tp5_empty",      32'(out_rob_full), 32'd0);
        alloc(9);
        chk("tp5_tag0", 32'(obs_dtag), 32'd0);

        // Stall: rdy low holds state and clears commit output.
        do_reset();
        alloc(11);
        cdb(0, 32'h3C, 1'b0, 32'd0);
        step(1'b0, 1'b1, 12, 1'b0, 0, 32'd0, 1'b0, 32'd0, 0, 0);
        chk("stall_no_commit", 32'(out_commit_reg), 32'd0);
        idle();
        chk("stall_late_commit", 32'(out_commit_reg), 32'd11);

        // Asynchronous reset mid-run with entries pending.
        do_reset();
        for (int i = 0; i < 4; i++) alloc(10 + i);
        cdb(0, 32'h99, 1'b0, 32'd0);
        idle();
        chk("tp6_pre_reg", 32'(out_commit_reg), 32'd10);
        #2;
        rst = 1'b1;
        #1;
        chk_reset_outputs("tp6_async");
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        alloc(4);
        chk("tp6_tag0", 32'(obs_dtag), 32'd0);

        // Randomized traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            bit          r;
            bit          dv;
            bit          cv;
            bit          cm;
            int          ct;
            if (m_count != 0 && $urandom_range(0, 7) != 0)
                ct = (m_head + int'($urandom_range(0, m_count - 1))) % 16;
            else
                ct = int'($urandom_range(0, 15));
            r  = ($urandom_range(0, 9) != 0);
            dv = ($urandom_range(0, 9) < 6);
            cv = ($urandom_range(0, 1) == 1);
            cm = ($urandom_range(0, 19) == 0);
            step(r, dv, int'($urandom_range(0, 31)), cv, ct, $urandom, cm, $urandom,
                 int'($urandom_range(0, 15)), int'($urandom_range(0, 15)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/reorder_buffer.md
Name: reorder_buffer

Overview:
- Circular in-order reorder buffer (ROB) that sits between the decoder, the common data bus (CDB) and the register file.
- Hands the decoder the ROB tag for each new instruction and captures results broadcast on the CDB.
- Retires entries in program order by driving the register-file commit interface (commit reg, commit ROB tag, commit value).
- On retiring a mispredicted entry it raises a one-cycle flush with a redirect PC and empties itself.

Parameters:
- ROB_SIZE, 16, number of entries (power of two).
- ROB_TAG_W, 4, log2(ROB_SIZE); a tag equals the entry index, and 0 is a valid tag.
- DATA_W, 32, result and PC width.
- REG_TAG_W, 5, architectural register index width.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- rdy  in  1  global ready; when low, all state holds.
- in_decode_valid  in  1  decoder requests allocation this cycle.
- in_decode_dest_reg  in  REG_TAG_W  destination register; 0 = no register write.
- out_decode_tag  out  ROB_TAG_W  tag assigned on allocation (= tail), combinational.
- out_rob_full  out  1  count==ROB_SIZE, from registered count.
- in_cdb_valid  in  1  CDB result valid.
- in_cdb_tag  in  ROB_TAG_W  producing entry.
- in_cdb_value  in  DATA_W  result value.
- in_cdb_mispredict  in  1  entry is a mispredicted control transfer.
- in_cdb_target_pc  in  DATA_W  correct PC for a mispredict.
- in_query_tag1 / in_query_tag2  in  ROB_TAG_W  operand tags from decoder.
- out_query_ready1 / out_query_ready2  out  1  operand value available, combinational.
- out_query_value1 / out_query_value2  out  DATA_W  operand value, combinational.
- out_commit_reg  out  REG_TAG_W  register written this cycle; 0 = no commit.
- out_commit_rob  out  ROB_TAG_W  tag of the retiring entry.
- out_commit_value  out  DATA_W  retiring value.
- out_flush  out  1  one-cycle pipeline flush.
- out_flush_pc  out  DATA_W  redirect PC.

Behaviour:
- **Reset (async, rst high):**
  - head=tail=count=0; all entry ready/mispredict bits cleared.
  - out_commit_reg=0, out_commit_rob=0, out_commit_value=0, out_flush=0, out_flush_pc=0.
- **rdy low:** head, tail, count and entries hold. Registered outputs update to out_commit_reg=0 and out_flush=0 at the next edge.
- **Entry fields:** dest_reg, value, ready, mispredict, target_pc.
- **Allocate** when in_decode_valid && !out_rob_full && !flush_now.
  - Entry[tail] gets dest_reg and ready=0, mispredict=0.
  - tail increments modulo ROB_SIZE (wraps from ROB_SIZE-1 to 0).
  - A request while full is ignored; the decoder must stall on out_rob_full.
- **CDB write:** when in_cdb_valid, entry[in_cdb_tag] gets value, ready=1, mispredict and target_pc. No range check against head/tail.
- **Commit** when count!=0 && entry[head].ready (state at the start of the cycle).
  - Registered outputs next edge: out_commit_reg=dest_reg, out_commit_rob=head, out_commit_value=value.
  - head increments modulo ROB_SIZE.
  - A CDB write to the head entry is committed one cycle later, never in the same cycle.
- **No commit:** out_commit_reg=0 at the next edge; out_commit_rob and out_commit_value are don't-care.
- **Count update:** +1 on alloc, -1 on commit; alloc and commit in the same cycle leave count unchanged. Full is evaluated before the commit, so no alloc occurs in a full cycle even if a commit frees a slot.
- **Flush (flush_now = commit && entry[head].mispredict):**
  - The entry still commits its value (link register).
  - out_flush=1 and out_flush_pc=target_pc for exactly one cycle.
  - head=tail=count=0 and all ready bits cleared.
  - Allocation and CDB writes in that cycle are discarded.
- **Query forwarding (per port):**
  - ready = entry[tag].ready || (in_cdb_valid && in_cdb_tag==tag).
  - value = CDB value on a CDB match, else entry value.
- **Latency:** allocation to earliest commit is 2 cycles (alloc cycle N, CDB in N+1, commit outputs after edge N+2).

Decomposition:
- Shared constants header gains ROB_SIZE, ROB_TAG_WIDTH, and a macro for the "no commit" register value (0).
- Flat module; no sub-module is warranted.

Test Plan:
- **Alloc/commit:** alloc dest 5 (tag 0), CDB tag 0 value 0x1234 -> next cycle out_commit_reg=5, out_commit_rob=0, out_commit_value=0x1234; then out_commit_reg=0.
- **Out-of-order completion:** alloc tags 0,1; CDB tag1=0xB then tag0=0xA -> commits tag0/0xA then tag1/0xB on consecutive cycles.
- **Full/wrap:** 16 allocs -> out_rob_full=1 and a 17th request is ignored. Commit one and alloc again -> new tag 0 (wrap), count stays 16.
- **Forwarding:** query tag 3 while CDB tag 3 value 0x77 is valid -> ready=1, value=0x77 combinationally.
- **Mispredict:** entries 0..2 allocated, CDB tag0 mispredict target 0x100 -> commit tag0, out_flush=1 and out_flush_pc=0x100 for one cycle; count=0, the next alloc gets tag 0.
- **Reset mid-run:** assert rst with 4 entries pending -> outputs 0 immediately (async); after release, the first alloc returns tag 0.
